// File: rtl/uart_fifo_trx_if.sv
// Valid/ready bundle between user logic and the UART transceiver FIFOs.
// The master side pushes TX bytes and pops RX bytes.
interface uart_fifo_trx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data_i;
  logic                 tx_valid_i;
  logic                 tx_ready_o;
  logic [DATA_BITS-1:0] rx_data_o;
  logic                 rx_valid_o;
  logic                 rx_ready_i;

  modport master (output tx_data_i, tx_valid_i, rx_ready_i,
                  input  tx_ready_o, rx_data_o, rx_valid_o);
  modport slave  (input  tx_data_i, tx_valid_i, rx_ready_i,
                  output tx_ready_o, rx_data_o, rx_valid_o);
endinterface

// File: rtl/uart_fifo_trx.sv
// Parametrised UART transceiver with first-word-fall-through TX and RX FIFOs.
// Per-frame parity, framing and overflow errors are reported as 1-cycle pulses.
module uart_fifo_trx #(
  parameter int CLK_FREQ   = 10000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        uart_rx_i,
  output logic                        uart_tx_o,
  uart_fifo_trx_if.slave              bus,
  output logic                        rx_parity_err_o,
  output logic                        rx_frame_err_o,
  output logic                        rx_overflow_o,
  output logic [$clog2(FIFO_DEPTH):0] tx_level_o,
  output logic [$clog2(FIFO_DEPTH):0] rx_level_o
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(STOP_BITS * CLKS_PER_BIT + 1);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DATA_BITS-1:0] r_txMem [FIFO_DEPTH];
  logic [AW-1:0]        r_txWr, r_txRd;
  logic [LW-1:0]        r_txCount;
  logic                 w_txFull, w_txPush, w_txPop;
  logic [DATA_BITS-1:0] w_txHead;

  assign w_txFull       = (r_txCount == FULL_LVL);
  assign bus.tx_ready_o = !w_txFull;
  assign w_txPush       = bus.tx_valid_i & !w_txFull;
  assign w_txHead       = r_txMem[r_txRd];
  assign tx_level_o     = r_txCount;

  always_ff @(posedge clk) begin
    if (w_txPush) r_txMem[r_txWr] <= bus.tx_data_i;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_txWr    <= '0;
      r_txRd    <= '0;
      r_txCount <= '0;
    end else begin
      if (w_txPush) r_txWr <= r_txWr + AW'(1);
      if (w_txPop)  r_txRd <= r_txRd + AW'(1);
      if (w_txPush && !w_txPop)      r_txCount <= r_txCount + LW'(1);
      else if (!w_txPush && w_txPop) r_txCount <= r_txCount - LW'(1);
    end
  end

  state_t               r_txState, w_txNext;
  logic [CW-1:0]        r_txCnt;
  logic [IW-1:0]        r_txIdx;
  logic [DATA_BITS-1:0] r_txShift;
  logic                 r_txPar, r_txLine, r_txAvail;
  logic                 w_txTick, w_txLineNext;

  // The line is registered from the next state, so it changes on the same edge as the FSM.
  always_comb begin
    w_txNext     = r_txState;
    w_txPop      = 1'b0;
    w_txLineNext = 1'b1;
    w_txTick     = (r_txState == S_STOP) ? (r_txCnt == STOP_END) : (r_txCnt == BIT_END);
    case (r_txState)
      S_IDLE:   if (r_txAvail) begin w_txPop = 1'b1; w_txNext = S_START; end
      S_START:  if (w_txTick) w_txNext = S_DATA;
      S_DATA:   if (w_txTick && r_txIdx == LAST_IDX) w_txNext = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (w_txTick) w_txNext = S_STOP;
      S_STOP: begin
        if (w_txTick) begin
          if (r_txAvail) begin w_txPop = 1'b1; w_txNext = S_START; end
          else w_txNext = S_IDLE;
        end
      end
      default:  w_txNext = S_IDLE;
    endcase
    case (w_txNext)
      S_START:  w_txLineNext = 1'b0;
      S_DATA:   w_txLineNext = (r_txState == S_DATA && w_txTick) ? r_txShift[1] : r_txShift[0];
      S_PARITY: w_txLineNext = r_txPar;
      default:  w_txLineNext = 1'b1;
    endcase
  end

  // r_txAvail is a one-edge-late view of occupancy, fixing launch latency at two edges.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_txState <= S_IDLE;
      r_txCnt   <= '0;
      r_txIdx   <= '0;
      r_txShift <= '0;
      r_txPar   <= 1'b0;
      r_txLine  <= 1'b1;
      r_txAvail <= 1'b0;
    end else begin
      r_txState <= w_txNext;
      r_txLine  <= w_txLineNext;
      r_txAvail <= (r_txCount != '0) && !w_txPop;
      r_txCnt   <= (r_txState == S_IDLE || w_txTick) ? '0 : r_txCnt + CW'(1);
      if (w_txPop) begin
        r_txShift <= w_txHead;
        r_txIdx   <= '0;
        r_txPar   <= (PARITY == 2) ? ~^w_txHead : ^w_txHead;
      end else if (r_txState == S_DATA && w_txTick) begin
        r_txShift <= r_txShift >> 1;
        r_txIdx   <= r_txIdx + IW'(1);
      end
    end
  end

  assign uart_tx_o = r_txLine;

  logic [DATA_BITS-1:0] r_rxMem [FIFO_DEPTH];
  logic [AW-1:0]        r_rxWr, r_rxRd;
  logic [LW-1:0]        r_rxCount;
  logic                 w_rxValid, w_rxFull, w_rxPush, w_rxPop;

  assign w_rxValid      = (r_rxCount != '0);
  assign w_rxFull       = (r_rxCount == FULL_LVL);
  assign w_rxPop        = bus.rx_ready_i & w_rxValid;
  assign bus.rx_valid_o = w_rxValid;
  assign bus.rx_data_o  = w_rxValid ? r_rxMem[r_rxRd] : '0;
  assign rx_level_o     = r_rxCount;

  logic [1:0]           r_rxSync;
  logic                 r_rxPrev, w_rxLine;
  state_t               r_rxState, w_rxNext;
  logic [CW-1:0]        r_rxCnt;
  logic [IW-1:0]        r_rxIdx;
  logic [DATA_BITS-1:0] r_rxShift;
  logic                 r_rxParBit, r_rxParErr, r_rxFrameErr, r_rxOvf;
  logic                 w_rxTick, w_rxDone, w_rxParBad, w_rxFrameBad, w_rxGood;

  assign w_rxLine = r_rxSync[1];

  always_ff @(posedge clk) begin
    if (w_rxPush) r_rxMem[r_rxWr] <= r_rxShift;
  end

  // Start is armed only by a 1->0 edge, so a line held low after a framing error stays ignored.
  always_comb begin
    w_rxNext = r_rxState;
    w_rxDone = 1'b0;
    w_rxTick = (r_rxState == S_START) ? (r_rxCnt == HALF_END) : (r_rxCnt == BIT_END);
    case (r_rxState)
      S_IDLE:   if (r_rxPrev && !w_rxLine) w_rxNext = S_START;
      S_START:  if (w_rxTick) w_rxNext = w_rxLine ? S_IDLE : S_DATA;
      S_DATA:   if (w_rxTick && r_rxIdx == LAST_IDX) w_rxNext = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (w_rxTick) w_rxNext = S_STOP;
      S_STOP:   if (w_rxTick) begin w_rxDone = 1'b1; w_rxNext = S_IDLE; end
      default:  w_rxNext = S_IDLE;
    endcase
    w_rxParBad   = (PARITY != 0) && (r_rxParBit != ((PARITY == 2) ? ~^r_rxShift : ^r_rxShift));
    w_rxFrameBad = !w_rxLine;
    w_rxGood     = w_rxDone && !w_rxParBad && !w_rxFrameBad;
    w_rxPush     = w_rxGood && (!w_rxFull || w_rxPop);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_rxSync     <= 2'b11;
      r_rxPrev     <= 1'b1;
      r_rxState    <= S_IDLE;
      r_rxCnt      <= '0;
      r_rxIdx      <= '0;
      r_rxShift    <= '0;
      r_rxParBit   <= 1'b0;
      r_rxParErr   <= 1'b0;
      r_rxFrameErr <= 1'b0;
      r_rxOvf      <= 1'b0;
      r_rxWr       <= '0;
      r_rxRd       <= '0;
      r_rxCount    <= '0;
    end else begin
      r_rxSync     <= {r_rxSync[0], uart_rx_i};
      r_rxPrev     <= w_rxLine;
      r_rxState    <= w_rxNext;
      r_rxCnt      <= (r_rxState == S_IDLE || w_rxTick) ? '0 : r_rxCnt + CW'(1);
      if (r_rxState == S_START) r_rxIdx <= '0;
      if (r_rxState == S_DATA && w_rxTick) begin
        r_rxShift <= {w_rxLine, r_rxShift[DATA_BITS-1:1]};
        r_rxIdx   <= r_rxIdx + IW'(1);
      end
      if (r_rxState == S_PARITY && w_rxTick) r_rxParBit <= w_rxLine;
      r_rxParErr   <= w_rxDone && w_rxParBad;
      r_rxFrameErr <= w_rxDone && w_rxFrameBad;
      r_rxOvf      <= w_rxGood && w_rxFull && !w_rxPop;
      if (w_rxPush) r_rxWr <= r_rxWr + AW'(1);
      if (w_rxPop)  r_rxRd <= r_rxRd + AW'(1);
      if (w_rxPush && !w_rxPop)      r_rxCount <= r_rxCount + LW'(1);
      else if (!w_rxPush && w_rxPop) r_rxCount <= r_rxCount - LW'(1);
    end
  end

  assign rx_parity_err_o = r_rxParErr;
  assign rx_frame_err_o  = r_rxFrameErr;
  assign rx_overflow_o   = r_rxOvf;
endmodule

// File: tb/tb_uart_fifo_trx.sv
// Directed bench for uart_fifo_trx: instance A is 8N1/depth 16 with optional loopback,
// instance B is 8O2/depth 4 driven bit-by-bit from the bench.
module tb_uart_fifo_trx;
  localparam int CPB     = 16;
  localparam int CLK_HZ  = 10000000;
  localparam int BAUD_TB = CLK_HZ / CPB;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_fifo_trx_if #(.DATA_BITS(8)) ifA ();
  uart_fifo_trx_if #(.DATA_BITS(8)) ifB ();

  logic       txA, rxA, lineA, loopA, perrA, ferrA, ovfA;
  logic [4:0] txLevA, rxLevA;
  logic       txB, rxB, lineB, perrB, ferrB, ovfB;
  logic [2:0] txLevB, rxLevB;

  assign rxA = loopA ? txA : lineA;
  assign rxB = lineB;

  uart_fifo_trx #(.CLK_FREQ(CLK_HZ), .BAUD(BAUD_TB), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(16)) dutA (
    .clk(clk), .rst_n(rst_n), .uart_rx_i(rxA), .uart_tx_o(txA), .bus(ifA),
    .rx_parity_err_o(perrA), .rx_frame_err_o(ferrA), .rx_overflow_o(ovfA),
    .tx_level_o(txLevA), .rx_level_o(rxLevA));

  uart_fifo_trx #(.CLK_FREQ(CLK_HZ), .BAUD(BAUD_TB), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(2), .FIFO_DEPTH(4)) dutB (
    .clk(clk), .rst_n(rst_n), .uart_rx_i(rxB), .uart_tx_o(txB), .bus(ifB),
    .rx_parity_err_o(perrB), .rx_frame_err_o(ferrB), .rx_overflow_o(ovfB),
    .tx_level_o(txLevB), .rx_level_o(rxLevB));

  int nPerrA = 0, nFerrA = 0, nOvfA = 0, nPerrB = 0, nFerrB = 0, nOvfB = 0;
  always @(negedge clk) begin
    if (perrA) nPerrA++;
    if (ferrA) nFerrA++;
    if (ovfA)  nOvfA++;
    if (perrB) nPerrB++;
    if (ferrB) nFerrB++;
    if (ovfB)  nOvfB++;
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] expA[$];
  logic [7:0] expB[$];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic driveBit(input bit toB, input logic b);
    if (toB) lineB = b; else lineA = b;
    repeat (CPB) @(negedge clk);
  endtask

  // Drives one serial frame; the line is left at the stop-bit value afterwards.
  task automatic applyStimulus(input bit toB, input logic [7:0] data, input bit hasPar,
                               input logic parBit, input logic stopBit);
    driveBit(toB, 1'b0);
    for (int i = 0; i < 8; i++) driveBit(toB, data[i]);
    if (hasPar) driveBit(toB, parBit);
    driveBit(toB, stopBit);
  endtask

  task automatic idleBits(input int n);
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic popCheck(input bit toB, input string tag);
    int n;
    logic v;
    logic [7:0] e;
    n = 0;
    v = toB ? ifB.rx_valid_o : ifA.rx_valid_o;
    while (!v && n < CPB * 40) begin
      @(negedge clk);
      n++;
      v = toB ? ifB.rx_valid_o : ifA.rx_valid_o;
    end
    checkOutput({tag, "_valid"}, {31'd0, v}, 32'd1);
    if (v) begin
      e = toB ? expB.pop_front() : expA.pop_front();
      checkOutput({tag, "_data"}, toB ? ifB.rx_data_o : ifA.rx_data_o, e);
      if (toB) ifB.rx_ready_i = 1'b1; else ifA.rx_ready_i = 1'b1;
      @(negedge clk);
      ifA.rx_ready_i = 1'b0;
      ifB.rx_ready_i = 1'b0;
    end
  endtask

  initial begin
    int sent, got, cyc, fallAt, lowRun, p0, f0, o0;
    logic prevTx;
    logic [7:0] d;
    logic [11:0] obs, expFrame;
    logic [7:0] burst [3];

    rst_n = 1'b1;
    loopA = 1'b0; lineA = 1'b1; lineB = 1'b1;
    ifA.tx_data_i = '0; ifA.tx_valid_i = 1'b0; ifA.rx_ready_i = 1'b0;
    ifB.tx_data_i = '0; ifB.tx_valid_i = 1'b0; ifB.rx_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_txA", txA, 1);
    checkOutput("rst_readyA", ifA.tx_ready_o, 1);
    checkOutput("rst_validA", ifA.rx_valid_o, 0);
    checkOutput("rst_dataA", ifA.rx_data_o, 0);
    checkOutput("rst_levelsA", {txLevA, rxLevA}, 0);
    checkOutput("rst_errsA", {perrA, ferrA, ovfA}, 0);
    checkOutput("rst_txB", txB, 1);
    checkOutput("rst_levelsB", {txLevB, rxLevB}, 0);
    rst_n = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] echo 0x00..0x1F through loopback");
    loopA = 1'b1;
    sent = 0; got = 0; cyc = 0; fallAt = -1; lowRun = -1; prevTx = 1'b1;
    p0 = nPerrA; f0 = nFerrA; o0 = nOvfA;
    while (got < 32 && cyc < 8000) begin
      if (sent < 32 && ifA.tx_ready_o) begin
        ifA.tx_data_i = sent[7:0];
        ifA.tx_valid_i = 1'b1;
        expA.push_back(sent[7:0]);
        sent++;
      end else ifA.tx_valid_i = 1'b0;
      if (ifA.rx_valid_o) begin
        checkOutput("echo_data", ifA.rx_data_o, expA.pop_front());
        ifA.rx_ready_i = 1'b1;
        got++;
      end else ifA.rx_ready_i = 1'b0;
      if (prevTx && !txA && fallAt < 0) fallAt = cyc;
      if (!prevTx && txA && fallAt >= 0 && lowRun < 0) lowRun = cyc - fallAt;
      prevTx = txA;
      @(negedge clk);
      cyc++;
    end
    ifA.tx_valid_i = 1'b0;
    ifA.rx_ready_i = 1'b0;
    checkOutput("echo_count", got, 32);
    checkOutput("echo_low_run", lowRun, 9 * CPB);
    checkOutput("echo_no_errs", (nPerrA - p0) + (nFerrA - f0) + (nOvfA - o0), 0);
    idleBits(2);
    loopA = 1'b0;

    $display("[TB] stop bit 0 followed by break");
    f0 = nFerrA;
    applyStimulus(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
    idleBits(20);
    lineA = 1'b1;
    idleBits(2);
    checkOutput("brk_ferr", nFerrA - f0, 1);
    checkOutput("brk_no_valid", ifA.rx_valid_o, 0);
    checkOutput("brk_level", rxLevA, 0);
    applyStimulus(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
    expA.push_back(8'h3C);
    popCheck(1'b0, "brk_next");

    $display("[TB] odd parity checking");
    d = 8'h5A;
    p0 = nPerrB;
    applyStimulus(1'b1, d, 1'b1, ^d, 1'b1);
    idleBits(2);
    checkOutput("par_bad_pulse", nPerrB - p0, 1);
    checkOutput("par_bad_no_valid", ifB.rx_valid_o, 0);
    checkOutput("par_bad_level", rxLevB, 0);
    applyStimulus(1'b1, d, 1'b1, ~^d, 1'b1);
    expB.push_back(d);
    popCheck(1'b1, "par_good");
    checkOutput("par_good_no_err", nPerrB - p0, 1);

    $display("[TB] RX overflow with depth 4");
    o0 = nOvfB;
    for (int i = 0; i < 6; i++) begin
      d = 8'h10 + 8'(i);
      applyStimulus(1'b1, d, 1'b1, ~^d, 1'b1);
      if (i < 4) expB.push_back(d);
    end
    idleBits(2);
    checkOutput("ovf_level", rxLevB, 4);
    checkOutput("ovf_pulses", nOvfB - o0, 2);
    for (int i = 0; i < 4; i++) popCheck(1'b1, "ovf_pop");
    checkOutput("ovf_drained", rxLevB, 0);

    $display("[TB] TX burst, two stop bits");
    burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33;
    ifB.tx_data_i = burst[0]; ifB.tx_valid_i = 1'b1;
    @(negedge clk);
    checkOutput("burst_lvl_n0", txLevB, 1);
    checkOutput("burst_idle_n0", txB, 1);
    ifB.tx_data_i = burst[1];
    @(negedge clk);
    checkOutput("burst_lvl_n1", txLevB, 2);
    checkOutput("burst_idle_n1", txB, 1);
    ifB.tx_data_i = burst[2];
    @(negedge clk);
    checkOutput("burst_lvl_n2", txLevB, 2);
    checkOutput("burst_fall_n2", txB, 0);
    ifB.tx_valid_i = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    for (int f = 0; f < 3; f++) begin
      obs = '0;
      for (int b = 0; b < 12; b++) begin
        obs[b] = txB;
        repeat (CPB) @(negedge clk);
      end
      expFrame = {2'b11, ~^burst[f], burst[f], 1'b0};
      checkOutput("burst_frame", obs, expFrame);
    end
    idleBits(1);
    checkOutput("burst_drained", txLevB, 0);
    checkOutput("burst_idle_end", txB, 1);

    $display("[TB] reset mid-frame");
    loopA = 1'b1;
    ifA.tx_data_i = 8'h81; ifA.tx_valid_i = 1'b1;
    @(negedge clk);
    ifA.tx_valid_i = 1'b0;
    idleBits(5);
    checkOutput("rst_mid_busy", txLevA, 0);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_mid_tx", txA, 1);
    checkOutput("rst_mid_levels", {txLevA, rxLevA}, 0);
    checkOutput("rst_mid_valid", ifA.rx_valid_o, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    idleBits(12);
    checkOutput("rst_no_partial", {ifA.rx_valid_o, rxLevA}, 0);
    ifA.tx_data_i = 8'h81; ifA.tx_valid_i = 1'b1;
    expA.push_back(8'h81);
    @(negedge clk);
    ifA.tx_valid_i = 1'b0;
    popCheck(1'b0, "rst_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_fifo_trx.md
Name: uart_fifo_trx

Overview:
Parametrised UART transceiver, the successor to the fixed 8N1 uart_reg echo block. It has configurable data width, parity and stop bits, plus independent TX and RX FIFOs with valid/ready interfaces. It sits between the board UART pins and user logic in the 10 MHz (PLL) clock domain and reports parity, framing and overflow errors per frame.

Parameters:
CLK_FREQ, 10000000, system clock in Hz
BAUD, 9600, line rate; CLKS_PER_BIT = CLK_FREQ/BAUD, integer division (1041 at defaults)
DATA_BITS, 8, payload bits per frame, legal 5..9
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits, 1 or 2
FIFO_DEPTH, 16, entries per FIFO, power of 2, >= 2

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset rst_n, asynchronous, active-high
uart_rx_i  in  1  serial input, asynchronous to clk, idle high
uart_tx_o  out  1  serial output, idle high
tx_data_i  in  DATA_BITS  byte to send
tx_valid_i  in  1  tx_data_i valid
tx_ready_o  out  1  TX FIFO can accept data
rx_data_o  out  DATA_BITS  head of RX FIFO
rx_valid_o  out  1  RX FIFO not empty
rx_ready_i  in  1  consumer pops head
rx_parity_err_o  out  1  1-cycle pulse, parity mismatch
rx_frame_err_o  out  1  1-cycle pulse, stop bit sampled 0
rx_overflow_o  out  1  1-cycle pulse, received frame dropped because RX FIFO full
tx_level_o  out  clog2(FIFO_DEPTH)+1  TX FIFO occupancy
rx_level_o  out  clog2(FIFO_DEPTH)+1  RX FIFO occupancy

Behaviour:
- Reset (rst_n=1), asynchronous: uart_tx_o=1; tx_ready_o=1; rx_valid_o=0; all error pulses 0; levels 0; both FIFOs emptied; both FSMs to IDLE; rx_data_o=0. A frame in progress is abandoned; no partial frame is resumed after reset release.
- FIFOs: first-word fall-through. Push on valid&ready. tx_ready_o = !tx_full. rx_valid_o = !rx_empty. rx_data_o is the head while rx_valid_o=1. A simultaneous push and pop leaves the level unchanged. Pointers wrap modulo FIFO_DEPTH.
- TX FSM states: IDLE -> START -> DATA -> PARITY (only if PARITY!=0) -> STOP -> IDLE. Each bit lasts CLKS_PER_BIT cycles.
  - In IDLE with FIFO non-empty: pop and enter START; uart_tx_o=0 is registered.
  - Latency: push into an empty TX FIFO at edge N -> uart_tx_o falls after edge N+2.
  - Data is sent LSB first. Parity bit = XOR of data (even), inverted for odd.
  - STOP lasts STOP_BITS*CLKS_PER_BIT. If the FIFO is non-empty at STOP end, the next START begins on the next cycle with no extra idle gap.
- RX path: uart_rx_i passes through a 2-FF synchronizer before any use.
  - RX FSM states: IDLE -> START -> DATA -> PARITY (optional) -> STOP -> IDLE.
  - IDLE: a synchronized 1->0 transition enters START.
  - START: sample at CLKS_PER_BIT/2. If the line is 1, treat it as a glitch and return to IDLE with no error. If 0, sample each following bit at its centre, CLKS_PER_BIT apart.
  - Only the first stop bit is checked. After it is sampled, the FSM returns to IDLE immediately to allow resync on the next start edge.
  - Frame complete with stop=1 and parity OK: push into RX FIFO; rx_valid_o rises 1 cycle after the stop sample. If the FIFO is full and rx_ready_i is not popping that cycle, drop the frame and pulse rx_overflow_o.
  - Parity error: drop the frame, pulse rx_parity_err_o.
  - Stop=0: drop the frame, pulse rx_frame_err_o, then wait in IDLE until the line reads 1 before re-arming (break handling).
  - If parity and frame errors coincide, both pulses fire in the same cycle.
- tx_data_i bits above DATA_BITS do not exist; widths follow DATA_BITS exactly.
- TX and RX are fully independent; tying uart_tx_o to uart_rx_i must return identical data.

Test Plan:
1. Defaults; external echo feeds uart_tx_o back to uart_rx_i; push 0x00..0x1F -> rx_data_o returns 0x00..0x1F in order, no error pulses, bit period 1041 clk.
2. PARITY=2; bench drives 0x5A with even parity bit -> rx_parity_err_o single pulse, rx_valid_o stays 0. Then a correct 0x5A -> rx_data_o=0x5A.
3. Bench drives 0xA5 with stop bit 0, then holds the line low 20 bit times, then idle -> one rx_frame_err_o pulse, no frame during the break; next 0x3C is received correctly.
4. FIFO_DEPTH=4; bench sends 6 frames 0x10..0x15 with rx_ready_i=0 -> rx_level_o=4, two rx_overflow_o pulses; pops return 0x10..0x13.
5. Push 0x11, 0x22, 0x33 in consecutive cycles into an idle TX; STOP_BITS=2 -> uart_tx_o falls 2 cycles after the first push. Frames are back-to-back, 2 stop bits each, no gaps; tx_level_o goes 1, 2, 2 during the burst, then drains to 0.
6. Assert rst_n mid-DATA of a TX frame and mid-RX frame -> uart_tx_o=1 immediately, levels 0, no rx_valid_o. After release, a new 0x81 transfer completes correctly.
